bit_serial_adder: RTL and testbench
===================================

BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; legal range 2..32.
REQ-002 Port clk_i, input, 1: single clock; all state changes on the rising edge.
REQ-003 Port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-004 Port start_i, input, 1: request a new addition; sampled only in IDLE.
REQ-005 Port a_i, input, WIDTH: operand A, captured on start acceptance.
REQ-006 Port b_i, input, WIDTH: operand B, captured on start acceptance.
REQ-007 Port cin_i, input, 1: carry-in, captured on start acceptance.
REQ-008 Port busy_o, output, 1: high whenever the state is not IDLE.
REQ-009 Port done_o, output, 1: one-cycle pulse; result is valid in this cycle.
REQ-010 Port sum_o, output, WIDTH: registered result, held until the next completion.
REQ-011 Port cout_o, output, 1: registered carry-out, held until the next completion.

Function
REQ-012 The block SHALL compute A+B+cin using one full-adder cell, one bit per RUN cycle, LSB first.
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 IDLE with start_i=1 SHALL, on that edge: load A, B into shift registers; load the carry flop with cin_i; clear the bit counter; go to RUN.
REQ-015 Each RUN edge SHALL:
- apply A[0], B[0] and carry to the cell;
- shift the cell sum into the MSB of the partial-sum register;
- shift A and B right by one;
- load carry with the cell carry-out;
- increment the counter.
REQ-016 On the RUN edge where counter==WIDTH-1, the block SHALL load sum_o and cout_o from the completed values and go to DONE.
REQ-017 DONE SHALL assert done_o for exactly one cycle, then go to IDLE on the next edge.
REQ-018 Latency: done_o SHALL be high in the cycle WIDTH+1 edges after the edge that accepted start_i.
REQ-019 Start back-to-back: a new start is accepted no earlier than the cycle after DONE, giving a throughput of one addition per WIDTH+2 cycles.
REQ-020 start_i SHALL be ignored in RUN and DONE; operands in flight SHALL be unaffected.
REQ-021 sum_o and cout_o SHALL NOT change during RUN; they hold the previous result.
REQ-022 Changes on a_i, b_i and cin_i after acceptance SHALL have no effect.
REQ-023 The counter SHALL be $clog2(WIDTH) bits wide and SHALL NOT wrap during a run.

Reset
REQ-024 rst_ni low SHALL immediately force:
- state to IDLE;
- busy_o, done_o, sum_o, cout_o to 0;
- counter, carry and shift registers to 0.
REQ-025 Reset mid-RUN SHALL abort the addition with no done_o pulse; the first start after release SHALL be accepted normally.

Configuration
REQ-026 With macro BIT_SERIAL_ADDER_OVF_EN defined:
- port ovf_o (output, 1) SHALL exist, reset to 0;
- ovf_o SHALL be loaded with the carry into the MSB XOR the carry out of the MSB, at the same edge as sum_o;
- ovf_o is the signed overflow flag.
REQ-027 Without the macro, ovf_o and its flop SHALL NOT exist; all other behaviour is identical.

Structure
REQ-028 Shared package bit_serial_adder_pkg SHALL hold:
- the state enum type (IDLE, RUN, DONE);
- the default-width constant.
REQ-029 The bit cell SHALL be one instance of the existing full_adder sub-module; this block adds no other sub-modules.
REQ-030 The full_adder instance has internal propagation delays; the clock period SHALL exceed its worst-case path (250 time units).

Verification (WIDTH=8, clock period 1000 time units)
REQ-031 Basic add: a=0x5A, b=0x3C, cin=0 -> done_o 9 edges after acceptance; sum_o=0x96, cout_o=0; ovf_o=1 if the macro is defined.
REQ-032 Carry ripple: a=0xFF, b=0x01, cin=0 -> sum_o=0x00, cout_o=1, ovf_o=0.
REQ-033 Carry-in with signed overflow: a=0x7F, b=0x00, cin=1 -> sum_o=0x80, cout_o=0, ovf_o=1.
REQ-034 Ignored start: start_i pulsed in cycle 3 of a run with a=0x11, b=0x22 -> a single done_o, sum_o=0x33, busy_o continuous.
REQ-035 Reset mid-run: rst_ni low during cycle 4 of RUN -> all outputs 0 and no done_o; a new 0x01+0x01 run then gives sum_o=0x02.
REQ-036 Hold: after a completed run, toggle a_i and b_i for 20 cycles with start_i=0 -> sum_o and cout_o unchanged, busy_o=0.

Source files
------------

// File: rtl/bit_serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package bit_serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used as the serial datapath of bit_serial_adder.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial A+B+cin adder, one bit per cycle LSB first through a single full_adder.
// Optional signed-overflow output ovf_o is enabled by defining BIT_SERIAL_ADDER_OVF_EN.
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
`ifdef BIT_SERIAL_ADDER_OVF_EN
  output logic             cout_o,
  output logic             ovf_o
`else
  output logic             cout_o
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] psum_q, psum_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             cell_s, cell_c;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  full_adder u_cell (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (carry_q),
    .s_o (cell_s),
    .c_o (cell_c)
  );

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          carry_d = cin_i;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        psum_d  = {cell_s, psum_q[WIDTH-1:1]};
        carry_d = cell_c;
        if (cnt_q == LAST) begin
          // Counter parks at its last value so it never wraps.
          sum_d   = {cell_s, psum_q[WIDTH-1:1]};
          cout_d  = cell_c;
          done_d  = 1'b1;
          state_d = DONE;
`ifdef BIT_SERIAL_ADDER_OVF_EN
          ovf_d   = carry_q ^ cell_c;
`endif
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef BIT_SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  assign ovf_o  = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed scoreboard bench for bit_serial_adder (WIDTH=8, 1000-unit clock).
module tb_bit_serial_adder;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic       clk_i;
  logic       rst_ni;
  logic       start_i;
  logic [7:0] a_i;
  logic [7:0] b_i;
  logic       cin_i;
  logic       busy_o;
  logic       done_o;
  logic [7:0] sum_o;
  logic       cout_o;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic       ovf_o;
`endif

  exp_t       sb[$];
  int         n_cmp;
  int         n_err;
  logic [7:0] prev_sum;
  logic       prev_cout;

  bit_serial_adder #(.WIDTH(8)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .cin_i   (cin_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .sum_o   (sum_o),
`ifdef BIT_SERIAL_ADDER_OVF_EN
    .cout_o  (cout_o),
    .ovf_o   (ovf_o)
`else
    .cout_o  (cout_o)
`endif
  );

  initial clk_i = 1'b0;
  always #500 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one addition from IDLE, optionally pulsing start_i in RUN cycle pulse_at.
  task automatic add(input logic [7:0] a, input logic [7:0] b, input logic cin, input int pulse_at);
    exp_t       e;
    logic [8:0] full;
    int         n;
    logic       seen;
    full   = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    e.sum  = full[7:0];
    e.cout = full[8];
    e.ovf  = (a[7] == b[7]) && (full[7] != a[7]);
    sb.push_back(e);
    a_i = a; b_i = b; cin_i = cin; start_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    n = 1;
    start_i = 1'b0;
    a_i = ~a; b_i = ~b; cin_i = ~cin;
    seen = 1'b0;
    while (n <= 20 && !seen) begin
      if (done_o === 1'b1) begin
        seen = 1'b1;
      end else begin
        chk("busy_run", {31'd0, busy_o}, 32'd1);
        chk("hold_run", {23'd0, cout_o, sum_o}, {23'd0, prev_cout, prev_sum});
        if (n == pulse_at) begin
          start_i = 1'b1; a_i = 8'hFF; b_i = 8'hFF;
        end else begin
          start_i = 1'b0;
        end
        @(negedge clk_i);
        n++;
      end
    end
    start_i = 1'b0;
    if (seen) chk("latency", n, 32'd9);
    else chk("timeout", 32'd0, 32'd1);
    e = sb.pop_front();
    chk("sum", {24'd0, sum_o}, {24'd0, e.sum});
    chk("cout", {31'd0, cout_o}, {31'd0, e.cout});
`ifdef BIT_SERIAL_ADDER_OVF_EN
    chk("ovf", {31'd0, ovf_o}, {31'd0, e.ovf});
`endif
    chk("busy_done", {31'd0, busy_o}, 32'd1);
    prev_sum  = e.sum;
    prev_cout = e.cout;
    @(negedge clk_i);
    chk("done_pulse", {31'd0, done_o}, 32'd0);
    chk("busy_idle", {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    int done_seen;
    n_cmp = 0; n_err = 0;
    prev_sum = 8'h00; prev_cout = 1'b0;
    rst_ni = 1'b0; start_i = 1'b0; a_i = 8'h00; b_i = 8'h00; cin_i = 1'b0;
    #100;
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_sum", {24'd0, sum_o}, 32'd0);
    chk("rst_cout", {31'd0, cout_o}, 32'd0);
`ifdef BIT_SERIAL_ADDER_OVF_EN
    chk("rst_ovf", {31'd0, ovf_o}, 32'd0);
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    add(8'h5A, 8'h3C, 1'b0, 0);
    add(8'hFF, 8'h01, 1'b0, 0);
    add(8'h7F, 8'h00, 1'b1, 0);
    add(8'h11, 8'h22, 1'b0, 3);
    add(8'h80, 8'h80, 1'b1, 0);

    // Abort a run with reset during its fourth RUN cycle.
    a_i = 8'h55; b_i = 8'h33; cin_i = 1'b0; start_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b0;
    #100;
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    chk("abort_done", {31'd0, done_o}, 32'd0);
    chk("abort_sum", {24'd0, sum_o}, 32'd0);
    chk("abort_cout", {31'd0, cout_o}, 32'd0);
`ifdef BIT_SERIAL_ADDER_OVF_EN
    chk("abort_ovf", {31'd0, ovf_o}, 32'd0);
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      if (done_o !== 1'b0) done_seen++;
    end
    chk("abort_no_done", done_seen, 32'd0);
    prev_sum = 8'h00; prev_cout = 1'b0;
    add(8'h01, 8'h01, 1'b0, 0);

    // Result holds while operands wiggle with no start.
    for (int i = 0; i < 20; i++) begin
      a_i = 8'($urandom); b_i = 8'($urandom); cin_i = 1'($urandom);
      @(negedge clk_i);
      chk("hold_idle", {22'd0, busy_o, cout_o, sum_o}, {22'd0, 1'b0, prev_cout, prev_sum});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
